// File: rtl/fp_div_pkg.sv
// Shared types and constants for the divider requester.
// The command entry layout is {tag, a, b}, with the tag in the top bits.
package fp_div_pkg;

    localparam int unsigned FP_TAG_W = 4;
    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2,
        DRAIN  = 2'd3
    } fp_req_state_t;

    typedef struct packed {
        logic [FP_TAG_W-1:0] tag;
        logic [31:0]         a;
        logic [31:0]         b;
    } fp_cmd_t;

endpackage

// File: rtl/fp_div_cmd_fifo.sv
// Command FIFO for tagged operand pairs.
// DEPTH must be a power of two so that the pointers wrap naturally.
module fp_div_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 68
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_requester.sv
// Initiator-side adapter for the handshaked single-precision divider: buffers tagged
// operand pairs, runs one divide at a time and returns tagged results, with timeout recovery.
module fp_div_requester
    import fp_div_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_a,
    input  logic [31:0]         cmd_b,
    input  logic [FP_TAG_W-1:0] cmd_tag,
    output logic [31:0]         div_a,
    output logic [31:0]         div_b,
    output logic                div_a_stb,
    output logic                div_b_stb,
    input  logic                div_a_ack,
    input  logic                div_b_ack,
    input  logic [31:0]         div_z,
    input  logic                div_z_stb,
    output logic                div_z_ack,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_z,
    output logic [FP_TAG_W-1:0] res_tag,
    output logic                res_err,
    output logic [15:0]         done_count
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    fp_req_state_t       state_q, state_d;
    fp_cmd_t             push_cmd, head_cmd;
    logic                fifo_full, fifo_empty, fifo_pop;
    logic [31:0]         op_a_q, op_b_q;
    logic [FP_TAG_W-1:0] op_tag_q;
    logic                a_stb_q, b_stb_q, a_hs, b_hs;
    logic [CW-1:0]       tmo_cnt_q;
    logic                z_take, tmo_fire;
    logic                res_valid_q, res_err_q;
    logic [31:0]         res_z_q;
    logic [FP_TAG_W-1:0] res_tag_q;
    logic [15:0]         done_count_q;

    assign push_cmd = '{tag: cmd_tag, a: cmd_a, b: cmd_b};

    fp_div_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fp_cmd_t))
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready  = !rst && !fifo_full;
    assign div_a      = op_a_q;
    assign div_b      = op_b_q;
    assign div_a_stb  = a_stb_q;
    assign div_b_stb  = b_stb_q;
    assign div_z_ack  = ((state_q == WAIT_Z) && !res_valid_q) || (state_q == DRAIN);
    assign res_valid  = res_valid_q;
    assign res_z      = res_z_q;
    assign res_tag    = res_tag_q;
    assign res_err    = res_err_q;
    assign done_count = done_count_q;

    assign a_hs = a_stb_q && div_a_ack;
    assign b_hs = b_stb_q && div_b_ack;

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        z_take   = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if ((!a_stb_q || a_hs) && (!b_stb_q || b_hs)) begin
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (div_z_stb && !res_valid_q) begin
                    z_take  = 1'b1;
                    state_d = IDLE;
                end else if (!res_valid_q && (tmo_cnt_q == TMO_LAST)) begin
                    tmo_fire = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                // The late answer for the timed-out operation is swallowed here.
                if (div_z_stb) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_tag_q     <= '0;
            a_stb_q      <= 1'b0;
            b_stb_q      <= 1'b0;
            tmo_cnt_q    <= '0;
            res_valid_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_z_q      <= '0;
            res_tag_q    <= '0;
            done_count_q <= '0;
        end else begin
            state_q <= state_d;

            if (fifo_pop) begin
                op_a_q   <= head_cmd.a;
                op_b_q   <= head_cmd.b;
                op_tag_q <= head_cmd.tag;
                a_stb_q  <= 1'b1;
                b_stb_q  <= 1'b1;
            end else begin
                if (a_hs) a_stb_q <= 1'b0;
                if (b_hs) b_stb_q <= 1'b0;
            end

            // Stalled downstream freezes the timeout as well as the z ack.
            if (state_q == SEND) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == WAIT_Z) && !res_valid_q && !tmo_fire) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (z_take) begin
                res_z_q     <= div_z;
                res_tag_q   <= op_tag_q;
                res_err_q   <= 1'b0;
                res_valid_q <= 1'b1;
            end else if (tmo_fire) begin
                res_z_q     <= FP_QNAN;
                res_tag_q   <= op_tag_q;
                res_err_q   <= 1'b1;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end

            if (res_valid_q && res_ready) begin
                done_count_q <= done_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_requester.sv
// Randomised bench for fp_div_requester: a behavioural divider drives the a/b/z ports and
// a queue of expected results (quotient or quiet NaN) is matched against the result stream.
module tb_fp_div_requester;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_tag;
    logic [31:0] div_a, div_b, div_z;
    logic        div_a_stb, div_b_stb, div_a_ack, div_b_ack, div_z_stb, div_z_ack;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_z;
    logic [3:0]  res_tag;
    logic [15:0] done_count;

    fp_div_requester #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_a_stb  (div_a_stb),
        .div_b_stb  (div_b_stb),
        .div_a_ack  (div_a_ack),
        .div_b_ack  (div_b_ack),
        .div_z      (div_z),
        .div_z_stb  (div_z_stb),
        .div_z_ack  (div_z_ack),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_z      (res_z),
        .res_tag    (res_tag),
        .res_err    (res_err),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %h, expected %h", tag, act, exp);
    endtask

    // Behavioural divider answer; 6.0 / 2.0 is exact, other pairs get an arbitrary mix.
    function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
    endfunction

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] z;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_done;
    int          ready_mode;     // 0 stall, 1 always ready, 2 random
    int          a_wait, b_wait, z_wait;
    bit          rnd_delays;

    // Divider model; everything is decided at the falling edge and seen by the next rising edge.
    initial begin : divider_model
        int   a_cnt, b_cnt, z_cnt;
        bit   have_a, have_b, a_hs, b_hs, z_ack_s;
        logic [31:0] got_a, got_b;
        div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0; div_z = '0;
        a_cnt = 0; b_cnt = 0; z_cnt = 0; have_a = 0; have_b = 0; a_hs = 0; b_hs = 0;
        z_ack_s = 0; got_a = '0; got_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0;
                a_cnt = 0; b_cnt = 0; z_cnt = 0; have_a = 0; have_b = 0;
                a_hs = 0; b_hs = 0; z_ack_s = 0;
                continue;
            end
            if (a_hs) check("a_stb_drop", {31'b0, div_a_stb}, 32'd0);
            if (b_hs) check("b_stb_drop", {31'b0, div_b_stb}, 32'd0);
            a_hs = 0; b_hs = 0;
            if (div_z_stb && z_ack_s) begin
                div_z_stb = 1'b0;
                have_a = 0; have_b = 0; a_cnt = 0; b_cnt = 0; z_cnt = 0;
                if (rnd_delays) begin
                    a_wait = $urandom_range(0, 3);
                    b_wait = $urandom_range(0, 3);
                    z_wait = $urandom_range(0, 5);
                end
            end
            div_a_ack = 1'b0; div_b_ack = 1'b0;
            if (div_a_stb && !have_a) begin
                if (a_cnt >= a_wait) begin
                    div_a_ack = 1'b1; have_a = 1; got_a = div_a; a_hs = 1;
                end else a_cnt++;
            end
            if (div_b_stb && !have_b) begin
                if (b_cnt >= b_wait) begin
                    div_b_ack = 1'b1; have_b = 1; got_b = div_b; b_hs = 1;
                end else b_cnt++;
            end
            if (have_a && have_b && !a_hs && !b_hs && !div_z_stb) begin
                if (z_cnt >= z_wait) begin
                    div_z_stb = 1'b1;
                    div_z     = div_fn(got_a, got_b);
                end else z_cnt++;
            end
            z_ack_s = div_z_ack;
        end
    end

    // Result consumer and scoreboard.
    initial begin : result_monitor
        exp_t e;
        res_ready = 1'b0;
        exp_done  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_done  = '0;
                res_ready = 1'b0;
                continue;
            end
            case (ready_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (res_valid && res_ready) begin
                check("done_count", {16'b0, done_count}, {16'b0, exp_done});
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {28'b0, res_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("res_z", res_z, e.z);
                    check("res_tag", {28'b0, res_tag}, {28'b0, e.tag});
                    check("res_err", {31'b0, res_err}, {31'b0, e.err});
                end
                exp_done = exp_done + 16'd1;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the push.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                            input bit err);
        exp_t e;
        int   guard = 0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_tag = tag;
        while (!cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'd0, 32'd1);
        end else begin
            e.tag = tag; e.z = err ? QNAN : div_fn(a, b); e.err = err;
            exp_q.push_back(e);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || res_valid) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_waits(input int a, input int b, input int z);
        a_wait = a; b_wait = b; z_wait = z;
    endtask

    initial begin : main
        int   guard;
        bit   stray;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        ready_mode = 1; rnd_delays = 0;
        set_waits(0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_a_stb", {31'b0, div_a_stb}, 32'd0);
        check("rst_z_ack", {31'b0, div_z_ack}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_z", res_z, 32'd0);
        check("rst_done", {16'b0, done_count}, 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);

        // Single operation with both acks in one cycle.
        send_cmd(32'h40C0_0000, 32'h4000_0000, 4'd3, 1'b0);
        wait_drain();
        check("single_done", {16'b0, done_count}, 32'd1);

        // Split acks: a two cycles ahead of b.
        set_waits(0, 2, 1);
        send_cmd(32'h3F80_0000, 32'h4080_0000, 4'd7, 1'b0);
        wait_drain();

        // Back-pressure: one result parked, one op stalled in WAIT_Z, FIFO full behind it.
        set_waits(0, 0, 0);
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            send_cmd($urandom, $urandom, 4'(i + 4), 1'b0);
        end
        repeat (20) @(negedge clk);
        check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("bp_z_ack", {31'b0, div_z_ack}, 32'd0);
        check("bp_res_valid", {31'b0, res_valid}, 32'd1);
        ready_mode = 1;
        wait_drain();

        // Timeout boundary: last in-time answer, first late one, and a clearly late one.
        set_waits(0, 0, TIMEOUT - 1);
        send_cmd(32'h4100_0000, 32'h4000_0000, 4'd1, 1'b0);
        wait_drain();
        set_waits(0, 0, TIMEOUT);
        send_cmd(32'h4100_0000, 32'h4040_0000, 4'd2, 1'b1);
        wait_drain();
        set_waits(1, 0, TIMEOUT + 3);
        send_cmd(32'h4120_0000, 32'h4040_0000, 4'd5, 1'b1);
        wait_drain();
        set_waits(0, 0, 0);
        send_cmd(32'h40C0_0000, 32'h4000_0000, 4'd6, 1'b0);
        wait_drain();

        // Random traffic with random divider latency and downstream stalls.
        ready_mode = 2; rnd_delays = 1;
        for (int i = 0; i < 40; i++) begin
            send_cmd($urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        ready_mode = 1;
        wait_drain();
        rnd_delays = 0;
        set_waits(0, 0, 0);

        // Counter wrap from a preloaded value.
        force dut.done_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.done_count_q;
        exp_done = 16'hFFFE;
        @(negedge clk);
        check("wrap_preload", {16'b0, done_count}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            send_cmd($urandom, $urandom, 4'(i + 10), 1'b0);
        end
        wait_drain();
        check("wrap_done", {16'b0, done_count}, 32'd1);

        // Reset while the strobes are up and the FIFO holds work.
        set_waits(8, 8, 0);
        for (int i = 0; i < 3; i++) begin
            send_cmd($urandom, $urandom, 4'(i), 1'b0);
        end
        guard = 0;
        while (!div_a_stb && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("pre_rst_a_stb", {31'b0, div_a_stb}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_a_stb", {31'b0, div_a_stb}, 32'd0);
        check("mid_rst_b_stb", {31'b0, div_b_stb}, 32'd0);
        check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("mid_rst_done", {16'b0, done_count}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        set_waits(0, 0, 0);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (div_a_stb || div_b_stb || res_valid) stray = 1;
        end
        check("post_rst_fifo_empty", {31'b0, stray}, 32'd0);
        send_cmd(32'h40C0_0000, 32'h4000_0000, 4'd9, 1'b0);
        wait_drain();
        check("post_rst_done", {16'b0, done_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
